spike_rate_decoder: RTL and testbench

Downstream consumer of the leaky integrate-and-fire neuron's `spike` output. It counts spikes over a programmable window of clock cycles and presents each window's count as a rate sample. Samples leave through a one-deep valid/ready output buffer, which lets the neuron tile's output logic or an external reader take rate values at its own pace.

---
 rtl/spike_rate_decoder.sv | 154 +++++++++++++++
 tb/tb_spike_rate_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Counts spikes from the LIF neuron over a programmable window of clock
//   cycles and presents each window's count as a rate sample through a
//   one-deep valid/ready output buffer.
//
//   Optional feature macro: SPIKE_ISI_EN
//     When defined, adds inter-spike interval tracking and the isi_out port.
//
// Ports:
//   clk         in   1      single clock, posedge
//   reset       in   1      asynchronous, active-high reset
//   enable      in   1      run decoder; low returns to IDLE
//   spike_in    in   1      registered spike from neuron
//   cfg_window  in   WIN_W  window length in cycles (0 treated as 1)
//   rate_data   out  CNT_W  spike count of last completed window
//   rate_sat    out  1      rate_data saturated during that window
//   rate_valid  out  1      output buffer holds an unread sample
//   rate_ready  in   1      consumer accepts when rate_valid && rate_ready
//   overrun     out  1      sticky: a completed window was dropped
//   isi_out     out  CNT_W  last inter-spike interval (SPIKE_ISI_EN only)
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] cfg_window,
  output logic [CNT_W-1:0] rate_data,
  output logic             rate_sat,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun
`ifdef SPIKE_ISI_EN
  ,
  output logic [CNT_W-1:0] isi_out
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             win_sat;
  logic [WIN_W-1:0] win_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_next;
  logic             hit_max;
  logic [WIN_W-1:0] win_load;
  logic             win_end;
  logic             accept;
  logic             buf_free;

  assign cnt_next = spike_in ? sat_inc(count) : count;
  assign hit_max  = spike_in && (count == CNT_MAX);
  assign win_load = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
  assign win_end  = (state == COUNT) && enable && (win_cnt == WIN_W'(1));
  assign accept   = rate_valid && rate_ready;
  // The slot is usable if empty or being drained on this very edge.
  assign buf_free = !rate_valid || rate_ready;

`ifdef SPIKE_ISI_EN
  logic [CNT_W-1:0] isi_cnt;
  logic [CNT_W-1:0] last_isi;
  logic             spike_seen;
  logic [CNT_W-1:0] last_isi_next;

  // A spike on the window's last edge must already be reflected in the
  // interval that travels with that window's sample.
  assign last_isi_next = (spike_in && spike_seen) ? sat_inc(isi_cnt) : last_isi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isi_cnt    <= '0;
      last_isi   <= '0;
      spike_seen <= 1'b0;
      isi_out    <= '0;
    end else begin
      if (state == IDLE) begin
        isi_cnt    <= '0;
        last_isi   <= '0;
        spike_seen <= 1'b0;
      end else if (enable) begin
        isi_cnt  <= spike_in ? '0 : sat_inc(isi_cnt);
        last_isi <= last_isi_next;
        if (spike_in) spike_seen <= 1'b1;
        if (win_end && buf_free) isi_out <= last_isi_next;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      win_sat    <= 1'b0;
      win_cnt    <= '0;
      rate_data  <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Consumer drain; a window end below may reload the slot this edge.
      if (accept) rate_valid <= 1'b0;

      case (state)
        IDLE: begin
          count   <= '0;
          win_sat <= 1'b0;
          win_cnt <= '0;
          if (enable) begin
            state   <= COUNT;
            win_cnt <= win_load;
            overrun <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            // Partial window is discarded; buffer and overrun survive.
            state   <= IDLE;
            count   <= '0;
            win_sat <= 1'b0;
            win_cnt <= '0;
          end else if (win_end) begin
            count   <= '0;
            win_sat <= 1'b0;
            win_cnt <= win_load;
            if (buf_free) begin
              rate_data  <= cnt_next;
              rate_sat   <= win_sat || hit_max;
              rate_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            count   <= cnt_next;
            win_sat <= win_sat || hit_max;
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

  localparam int CNT_W = 4;
  localparam int WIN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             spike_in;
  logic [WIN_W-1:0] cfg_window;
  logic [CNT_W-1:0] rate_data;
  logic             rate_sat;
  logic             rate_valid;
  logic             rate_ready;
  logic             overrun;
`ifdef SPIKE_ISI_EN
  logic [CNT_W-1:0] isi_out;
`endif

  spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .cfg_window (cfg_window),
    .rate_data  (rate_data),
    .rate_sat   (rate_sat),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun)
`ifdef SPIKE_ISI_EN
    ,
    .isi_out    (isi_out)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic       en;
    logic       spk;
    logic [7:0] cfg;
    logic       rdy;
    logic [3:0] d;
    logic       s;
    logic       v;
    logic       o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic spk, input logic [7:0] cfg,
                     input logic rdy, input logic [3:0] d, input logic s,
                     input logic v, input logic o);
    vec_t t;
    t.en = en; t.spk = spk; t.cfg = cfg; t.rdy = rdy;
    t.d = d; t.s = s; t.v = v; t.o = o;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic spk, input logic [7:0] cfg, input logic rdy);
    enable = en; spike_in = spk; cfg_window = cfg; rate_ready = rdy;
  endtask

  initial begin
    // Each row: inputs at an edge, expected outputs just after it.
    //   en spk cfg rdy | data sat valid overrun
    add(1, 0, 4, 1,  0, 0, 0, 0);   // E0, window 4
    add(1, 1, 4, 1,  0, 0, 0, 0);   // edge 1 spike
    add(1, 0, 4, 1,  0, 0, 0, 0);
    add(1, 0, 4, 1,  0, 0, 0, 0);
    add(1, 1, 4, 1,  2, 0, 1, 0);   // edge 4 spike included
    add(1, 0, 4, 1,  2, 0, 0, 0);   // drained
    add(1, 1, 4, 1,  2, 0, 0, 0);
    add(1, 1, 4, 1,  2, 0, 0, 0);
    add(1, 1, 0, 1,  3, 0, 1, 0);   // window end; cfg 0 -> next window 1
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 1, 0, 1, 0);  // N=1 back to back
    add(1, 1, 3, 1,  1, 0, 1, 0);   // next window 3
    add(1, 1, 3, 0,  1, 0, 1, 0);   // consumer stalls
    add(1, 1, 3, 0,  1, 0, 1, 0);
    add(1, 0, 3, 0,  1, 0, 1, 1);   // sample 2 dropped
    add(1, 1, 3, 0,  1, 0, 1, 1);
    add(1, 1, 3, 0,  1, 0, 1, 1);
    add(1, 1, 3, 0,  1, 0, 1, 1);   // sample 3 dropped
    add(1, 0, 3, 1,  1, 0, 0, 1);   // first sample consumed
    add(1, 1, 3, 1,  1, 0, 0, 1);
    add(1, 1, 3, 1,  2, 0, 1, 1);
    add(0, 0, 3, 1,  2, 0, 0, 1);   // to IDLE, overrun kept
    add(1, 0, 5, 1,  2, 0, 0, 0);   // re-enable clears overrun
    add(1, 1, 5, 1,  2, 0, 0, 0);   // edge 1
    add(0, 1, 5, 1,  2, 0, 0, 0);   // drop on edge 2 of 5
    add(1, 0, 5, 1,  2, 0, 0, 0);   // E0 again
    add(1, 1, 5, 1,  2, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 5, 1, 2, 0, 0, 0);
    add(1, 0, 20, 1, 1, 0, 1, 0);   // only new window's spike
    for (int i = 0; i < 19; i++) add(1, 1, 20, 1, 1, 0, 0, 0);
    add(1, 1, 20, 1, 15, 1, 1, 0);  // saturated count
    add(0, 0, 20, 1, 15, 1, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0);
    #12;
    chk("reset_data",    rate_data,  0);
    chk("reset_sat",     rate_sat,   0);
    chk("reset_valid",   rate_valid, 0);
    chk("reset_overrun", overrun,    0);
`ifdef SPIKE_ISI_EN
    chk("reset_isi",     isi_out,    0);
`endif
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].spk, tbl[i].cfg, tbl[i].rdy);
      step();
      chk($sformatf("row%0d_data", i),    rate_data,  tbl[i].d);
      chk($sformatf("row%0d_sat", i),     rate_sat,   tbl[i].s);
      chk($sformatf("row%0d_valid", i),   rate_valid, tbl[i].v);
      chk($sformatf("row%0d_overrun", i), overrun,    tbl[i].o);
    end

    // Asynchronous reset in the middle of a window.
    drive(1, 1, 4, 0);
    step();
    step();
    #3 reset = 1'b1;
    #1;
    chk("async_rst_data",  rate_data,  0);
    chk("async_rst_sat",   rate_sat,   0);
    chk("async_rst_valid", rate_valid, 0);
    drive(1, 1, 2, 1);
    #2 reset = 1'b0;
    step();
    chk("post_rst_e0_valid", rate_valid, 0);
    step();
    step();
    chk("post_rst_data",  rate_data,  2);
    chk("post_rst_valid", rate_valid, 1);

`ifdef SPIKE_ISI_EN
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    drive(1, 0, 8, 1);
    step();
    for (int e = 1; e <= 8; e++) begin
      drive(1, (e == 2 || e == 5 || e == 6), 8, 1);
      step();
    end
    chk("isi_data",  rate_data,  3);
    chk("isi_valid", rate_valid, 1);
    chk("isi_value", isi_out,    1);
    drive(0, 0, 8, 1);
    step();
    drive(1, 0, 8, 1);
    step();
    for (int e = 1; e <= 8; e++) begin
      drive(1, (e == 3), 8, 1);
      step();
    end
    chk("isi_single_data", rate_data, 1);
    chk("isi_single_zero", isi_out,   0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
